// File: rtl/adc_spi_reader.sv
// Periodic CNV/SPI serial ADC reader: starts conversions, shifts results in
// MSB-first and presents each sample with a one-cycle valid strobe.
module adc_spi_reader #(
    parameter int DATA_BITS     = 16,
    parameter int CLK_DIV       = 4,
    parameter int CONV_CYCLES   = 40,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 adc_sdo,
    output logic                 adc_cnv,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    output logic [DATA_BITS-1:0] adc_data,
    output logic                 valid_out,
    output logic [15:0]          sample_cnt,
    output logic                 overrun
);

    localparam int HALVES = 2 * DATA_BITS;
    localparam int HW     = $clog2(HALVES);
    localparam int CMAX   = (CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV;
    localparam int CW     = $clog2(CMAX + 1);
    localparam int TW     = $clog2(SAMPLE_PERIOD);

    typedef enum logic [1:0] {IDLE, CONVERT, SHIFT, DONE} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [HW-1:0]        half, half_n;
    logic [TW-1:0]        timer;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_n;
    logic [15:0]          sample_cnt_n;
    logic                 cnv_n, cs_n_n, sclk_n, valid_n, overrun_n;
    logic                 tick;

    assign tick = enable && (timer == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            timer <= '0;
        end else if (!enable || timer == TW'(SAMPLE_PERIOD - 1)) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            half       <= '0;
            shreg      <= '0;
            adc_cnv    <= 1'b0;
            adc_cs_n   <= 1'b1;
            adc_sclk   <= 1'b0;
            adc_data   <= '0;
            valid_out  <= 1'b0;
            sample_cnt <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            half       <= half_n;
            shreg      <= shreg_n;
            adc_cnv    <= cnv_n;
            adc_cs_n   <= cs_n_n;
            adc_sclk   <= sclk_n;
            adc_data   <= data_n;
            valid_out  <= valid_n;
            sample_cnt <= sample_cnt_n;
            overrun    <= overrun_n;
        end
    end

    // Outputs are computed for the next state so they come straight from flops.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        half_n       = half;
        shreg_n      = shreg;
        cnv_n        = 1'b0;
        cs_n_n       = 1'b1;
        sclk_n       = 1'b0;
        valid_n      = 1'b0;
        data_n       = adc_data;
        sample_cnt_n = sample_cnt;
        overrun_n    = enable ? overrun : 1'b0;
        if (tick && state != IDLE) begin
            overrun_n = 1'b1;
        end
        unique case (state)
            IDLE: begin
                if (tick) begin
                    state_n = CONVERT;
                    cnt_n   = '0;
                    cnv_n   = 1'b1;
                end
            end
            CONVERT: begin
                if (cnt == CW'(CONV_CYCLES - 1)) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                    half_n  = '0;
                    cs_n_n  = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                    cnv_n = 1'b1;
                end
            end
            SHIFT: begin
                cs_n_n = 1'b0;
                sclk_n = half[0];
                cnt_n  = cnt + CW'(1);
                if (cnt == CW'(CLK_DIV - 1)) begin
                    cnt_n = '0;
                    if (half == HW'(HALVES - 1)) begin
                        state_n      = DONE;
                        cs_n_n       = 1'b1;
                        sclk_n       = 1'b0;
                        valid_n      = 1'b1;
                        data_n       = shreg;
                        sample_cnt_n = sample_cnt + 16'd1;
                    end else begin
                        half_n = half + HW'(1);
                        sclk_n = ~half[0];
                        // Capture on the edge that raises sclk.
                        if (!half[0]) begin
                            shreg_n = DATA_BITS'({shreg, adc_sdo});
                        end
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Scoreboard bench for adc_spi_reader: two instances (sample period 100 and 50)
// with behavioural serial ADC models.
module tb_adc_spi_reader;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic        sdo_a = 1'b0;
    logic        sdo_b = 1'b0;
    logic        a_cnv, a_cs_n, a_sclk, a_valid, a_ovr;
    logic        b_cnv, b_cs_n, b_sclk, b_valid, b_ovr;
    logic [15:0] a_data, a_cnt, b_data, b_cnt;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [15:0] words_a[$];
    logic [15:0] words_b[$];
    logic [15:0] cur_a = '0;
    logic [15:0] cur_b = '0;
    int   idx_a = 0;
    int   idx_b = 0;

    adc_spi_reader #(
        .DATA_BITS(16), .CLK_DIV(2), .CONV_CYCLES(4), .SAMPLE_PERIOD(100)
    ) u_a (
        .clk(clk), .rst(rst), .enable(en_a), .adc_sdo(sdo_a),
        .adc_cnv(a_cnv), .adc_cs_n(a_cs_n), .adc_sclk(a_sclk),
        .adc_data(a_data), .valid_out(a_valid), .sample_cnt(a_cnt),
        .overrun(a_ovr)
    );

    adc_spi_reader #(
        .DATA_BITS(16), .CLK_DIV(2), .CONV_CYCLES(4), .SAMPLE_PERIOD(50)
    ) u_b (
        .clk(clk), .rst(rst), .enable(en_b), .adc_sdo(sdo_b),
        .adc_cnv(b_cnv), .adc_cs_n(b_cs_n), .adc_sclk(b_sclk),
        .adc_data(b_data), .valid_out(b_valid), .sample_cnt(b_cnt),
        .overrun(b_ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cyc != n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ADC models: MSB on chip-select fall, next bit after each sclk fall.
    always @(negedge a_cs_n) begin
        cur_a = (words_a.size() > 0) ? words_a.pop_front() : 16'h0;
        idx_a = 15;
        sdo_a = cur_a[15];
    end
    always @(negedge a_sclk) begin
        if (!a_cs_n && idx_a > 0) begin
            idx_a--;
            sdo_a = cur_a[idx_a];
        end
    end
    always @(negedge b_cs_n) begin
        cur_b = (words_b.size() > 0) ? words_b.pop_front() : 16'h0;
        idx_b = 15;
        sdo_b = cur_b[15];
    end
    always @(negedge b_sclk) begin
        if (!b_cs_n && idx_b > 0) begin
            idx_b--;
            sdo_b = cur_b[idx_b];
        end
    end

    // Monitors
    always @(negedge clk) begin
        if (a_valid) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_valid", {16'h0, a_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_valid_cycle", cyc, e.cyc);
                check("a_data", {16'h0, a_data}, {16'h0, e.data});
                check("a_sample_cnt", {16'h0, a_cnt}, {16'h0, e.cnt});
            end
        end
        if (b_valid) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_valid", {16'h0, b_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_valid_cycle", cyc, e.cyc);
                check("b_data", {16'h0, b_data}, {16'h0, e.data});
                check("b_sample_cnt", {16'h0, b_cnt}, {16'h0, e.cnt});
            end
        end
    end

    initial begin
        int t0;
        int ncnv;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_cnv", a_cnv, 0);
        check("rst_cs_n", a_cs_n, 1);
        check("rst_sclk", a_sclk, 0);
        check("rst_data", a_data, 0);
        check("rst_valid", a_valid, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_overrun", a_ovr, 0);
        check("rst_b_cs_n", b_cs_n, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic transfer with waveform checks
        t0 = cyc;
        words_a.push_back(16'hA5C3);
        q_a.push_back('{t0 + 69, 16'hA5C3, 16'd1});
        en_a = 1'b1;
        for (int c = 0; c <= 70; c++) begin
            goto(t0 + c);
            @(negedge clk);
            check("basic_cnv", a_cnv, (c >= 1 && c <= 4));
            check("basic_cs_n", a_cs_n, !(c >= 5 && c <= 68));
            check("basic_sclk", a_sclk,
                  (c >= 5 && c <= 68) && ((((c - 5) / 2) % 2) == 1));
        end
        goto(t0 + 75);
        en_a = 1'b0;
        rst = 1'b0;
        goto(t0 + 76);
        rst = 1'b1;

        // Periodic sampling
        t0 = cyc;
        words_a.push_back(16'h0001);
        words_a.push_back(16'hFFFE);
        q_a.push_back('{t0 + 69, 16'h0001, 16'd1});
        q_a.push_back('{t0 + 169, 16'hFFFE, 16'd2});
        en_a = 1'b1;
        goto(t0 + 120);
        @(negedge clk);
        check("hold_data", a_data, 16'h0001);
        goto(t0 + 172);
        @(negedge clk);
        check("periodic_overrun", a_ovr, 0);
        goto(t0 + 175);
        en_a = 1'b0;

        // Reset in the middle of SHIFT
        goto(t0 + 180);
        t0 = cyc;
        words_a.push_back(16'h5A5A);
        en_a = 1'b1;
        goto(t0 + 30);
        @(negedge clk);
        check("pre_reset_cs_n", a_cs_n, 0);
        rst = 1'b0;
        en_a = 1'b0;
        goto(t0 + 31);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs_n", a_cs_n, 1);
        check("midrst_sclk", a_sclk, 0);
        check("midrst_cnv", a_cnv, 0);
        check("midrst_data", a_data, 0);
        check("midrst_cnt", a_cnt, 0);
        goto(t0 + 120);

        // Enable dropped during a transfer
        t0 = cyc;
        words_a.push_back(16'h3C96);
        q_a.push_back('{t0 + 69, 16'h3C96, 16'd1});
        en_a = 1'b1;
        goto(t0 + 10);
        en_a = 1'b0;
        ncnv = 0;
        for (int c = 71; c <= 200; c++) begin
            goto(t0 + c);
            @(negedge clk);
            if (a_cnv) ncnv++;
        end
        check("no_restart_cnv", ncnv, 0);
        check("endrop_overrun", a_ovr, 0);

        // Sample counter wrap
        force u_a.sample_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release u_a.sample_cnt;
        t0 = cyc;
        words_a.push_back(16'h0F0F);
        q_a.push_back('{t0 + 69, 16'h0F0F, 16'h0000});
        en_a = 1'b1;
        goto(t0 + 75);
        en_a = 1'b0;

        // Overrun on the 50-cycle instance
        goto(t0 + 80);
        t0 = cyc;
        words_b.push_back(16'h1234);
        words_b.push_back(16'h8001);
        q_b.push_back('{t0 + 69, 16'h1234, 16'd1});
        q_b.push_back('{t0 + 169, 16'h8001, 16'd2});
        en_b = 1'b1;
        goto(t0 + 50);
        @(negedge clk);
        check("ovr_before_tick", b_ovr, 0);
        goto(t0 + 51);
        @(negedge clk);
        check("ovr_after_tick", b_ovr, 1);
        goto(t0 + 172);
        @(negedge clk);
        check("ovr_sticky", b_ovr, 1);
        goto(t0 + 175);
        en_b = 1'b0;
        goto(t0 + 176);
        @(negedge clk);
        check("ovr_cleared", b_ovr, 0);

        goto(t0 + 200);
        check("a_pending", q_a.size(), 0);
        check("b_pending", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
- Upstream front end of the ADC sample path. Periodically starts a conversion on an external serial ADC (CNV/SPI style, MSB-first) and clocks out the result.
- Presents each sample as `adc_data` with a one-cycle `valid_out` strobe, for direct connection to the scaling stage's `adc_data`/`valid_in`.
- Counts delivered samples and flags sample-rate overruns.

Parameters:
- DATA_BITS, 16: ADC word width; also the width of `adc_data`.
- CLK_DIV, 4: `clk` cycles per half-period of `adc_sclk`; must be ≥1.
- CONV_CYCLES, 40: `clk` cycles `adc_cnv` is held high (conversion time); must be ≥1.
- SAMPLE_PERIOD, 1000: `clk` cycles between conversion starts; must be ≥2.

Ports:
- clk, in, 1: system clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-low reset.
- enable, in, 1: 1 = run periodic sampling.
- adc_sdo, in, 1: ADC serial data; changes after `adc_sclk` falling edges.
- adc_cnv, out, 1: conversion start; high during CONVERT.
- adc_cs_n, out, 1: ADC chip select, active low during SHIFT.
- adc_sclk, out, 1: serial clock; idles low.
- adc_data, out, DATA_BITS: last captured sample.
- valid_out, out, 1: one-cycle strobe; `adc_data` is new in this cycle.
- sample_cnt, out, 16: count of `valid_out` pulses; wraps 0xFFFF→0x0000.
- overrun, out, 1: sticky; a period tick arrived while a transfer was still in progress.

Behaviour:
- Reset (`rst`=0 at a clk edge), effective at that edge, also mid-transfer:
  - FSM = IDLE, period timer = 0.
  - adc_cnv=0, adc_cs_n=1, adc_sclk=0, adc_data=0, valid_out=0, sample_cnt=0, overrun=0.
- Period timer:
  - While `enable`=0: held at 0, no ticks.
  - While `enable`=1: counts 0..SAMPLE_PERIOD-1 and wraps.
  - A tick is asserted in every cycle where `enable`=1 and timer=0. The first tick therefore occurs in the first cycle `enable` is sampled high.
- FSM states: IDLE, CONVERT, SHIFT, DONE.
- IDLE:
  - Outputs: adc_cnv=0, adc_cs_n=1, adc_sclk=0.
  - On tick → CONVERT at the next edge.
- CONVERT:
  - adc_cnv=1 for exactly CONV_CYCLES cycles; adc_cs_n=1.
  - Then → SHIFT.
- SHIFT:
  - adc_cs_n=0 for exactly 2·CLK_DIV·DATA_BITS cycles.
  - adc_sclk starts low and toggles every CLK_DIV cycles, giving DATA_BITS full periods.
  - `adc_sdo` is shifted in (MSB first) at the same clk edge that drives `adc_sclk` 0→1.
  - After the last high half-period, `adc_sclk` returns low → DONE.
- DONE (one cycle):
  - adc_cs_n=1, adc_sclk=0.
  - adc_data ← shift register; valid_out=1; sample_cnt += 1 (mod 2^16).
  - → IDLE.
- Registered outputs: adc_cnv, adc_cs_n, adc_sclk, valid_out, adc_data. No combinational path from inputs to outputs.
- Latency: tick cycle T → valid_out high in cycle T + CONV_CYCLES + 2·CLK_DIV·DATA_BITS + 1.
  - With defaults: T + 169.
  - Minimum safe SAMPLE_PERIOD = latency value + 1.
- Tick while FSM ≠ IDLE:
  - Tick is dropped; overrun ← 1.
  - The transfer in progress is unaffected.
  - The next accepted tick is the next one that finds IDLE.
- `overrun` clears only on reset or on a cycle with `enable`=0.
- `enable` deasserted mid-transfer:
  - The current transfer runs to DONE and delivers its sample; no further starts.
  - `overrun` is cleared.
- `adc_data` holds its value between strobes.
- `valid_out` is never high for two consecutive cycles.

Test Plan:
- Basic transfer. Setup: CLK_DIV=2, CONV_CYCLES=4, SAMPLE_PERIOD=100, DATA_BITS=16; ADC model returns 0xA5C3; enable high at cycle 0.
  - adc_cnv high in cycles 1–4.
  - adc_cs_n low in cycles 5–68, with 16 sclk periods of 4 cycles each.
  - valid_out in cycle 69 only; adc_data=0xA5C3; sample_cnt=1.
- Periodic sampling. Same setup, ADC model returns 0x0001 then 0xFFFE.
  - valid_out in cycles 69 and 169.
  - adc_data=0x0001 then 0xFFFE; no overrun.
- Overrun. SAMPLE_PERIOD=50, other parameters as in the basic transfer.
  - Tick at cycle 50 is dropped; overrun=1 from cycle 51.
  - Samples delivered at cycles 69 and 169 (second transfer starts from the tick at cycle 100).
  - Dropping enable for 1 cycle clears overrun.
- Reset mid-SHIFT. Assert rst=0 at cycle 30 of the basic transfer.
  - At cycle 31: adc_cs_n=1, adc_sclk=0, adc_cnv=0, adc_data=0, sample_cnt=0.
  - No valid_out pulse.
- Enable drop mid-transfer. Drop enable at cycle 10 of the basic transfer.
  - Sample still delivered at cycle 69.
  - FSM stays in IDLE afterwards; no adc_cnv.
- Counter wrap. Force 65536 transfers (or preload via hierarchical force to 0xFFFF), then one more transfer.
  - sample_cnt goes 0xFFFF→0x0000 on that valid_out.
